// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU datapath: opcode encodings, FSM state
// encoding and default widths.
package uart_alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_GET_A   = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_intf_alu.sv
// Purely combinational ALU: (A, B, opcode) -> (result, invalid).
// Unsupported opcodes produce a zero result and raise o_invalid.
module alu
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_invalid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        o_result  = '0;
        o_invalid = 1'b0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            // Shift amounts >= NB_DATA saturate to all sign bits / zero by
            // language semantics, so no explicit range check is needed.
            OP_SRA: o_result = $unsigned($signed(i_a) >>> i_b);
            OP_SRL: o_result = i_a >> i_b;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_intf.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// evaluates them and hands the result to the transmitter. Optional inter-byte
// timeout enabled with UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_op_err,
    output logic               o_overrun
);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               overrun_q, overrun_d;
    logic [NB_DATA-1:0] alu_result;
    logic               alu_invalid;
    logic               in_busy_state;
    logic               timeout;

    alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a       (a_q),
        .i_b       (b_q),
        .i_op      (op_q),
        .o_result  (alu_result),
        .o_invalid (alu_invalid)
    );

    assign in_busy_state = (state_q == ST_EXEC) || (state_q == ST_SEND) ||
                           (state_q == ST_WAIT_TX);

`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    assign waiting = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    assign timeout = waiting && !i_rx_valid &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles between bytes of a partially received frame.
    always_comb begin
        cnt_d = '0;
        if (waiting && !i_rx_valid && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_GET_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        overrun_d = i_rx_valid && in_busy_state;
        case (state_q)
            ST_GET_A: begin
                if (i_rx_valid) begin
                    a_d     = i_rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (i_rx_valid) begin
                    b_d     = i_rx_data;
                    state_d = ST_GET_OP;
                end else if (timeout) begin
                    state_d = ST_GET_A;
                end
            end
            ST_GET_OP: begin
                if (i_rx_valid) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = ST_EXEC;
                end else if (timeout) begin
                    state_d = ST_GET_A;
                end
            end
            ST_EXEC: begin
                tx_data_d = alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
            end
        endcase
    end

    always_comb begin
        o_busy     = in_busy_state;
        o_tx_start = (state_q == ST_SEND);
        o_op_err   = (state_q == ST_EXEC) && alu_invalid;
        o_tx_data  = tx_data_q;
        o_overrun  = overrun_q;
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed-vector bench for uart_alu_intf; define UART_ALU_INTF_TIMEOUT_EN to
// also exercise the inter-byte timeout with a short TIMEOUT_CYCLES.
module tb_uart_alu_intf;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 100;
`else
    localparam int TIMEOUT_CYCLES = 1_000_000;
`endif

    logic       i_clk;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_tx_done;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_op_err;
    logic       o_overrun;

    int n_vec;
    int n_err;

    uart_alu_intf #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_busy     (o_busy),
        .o_op_err   (o_op_err),
        .o_overrun  (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; DUT captures on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Called right after the opcode byte: now in EXEC, then SEND, then WAIT_TX.
    task automatic check_result(input string tag, input logic [7:0] exp,
                                input logic exp_err);
        check({tag, " busy@exec"}, o_busy, 1'b1);
        check({tag, " op_err@exec"}, o_op_err, exp_err);
        check({tag, " start@exec"}, o_tx_start, 1'b0);
        @(negedge i_clk);
        check({tag, " start@send"}, o_tx_start, 1'b1);
        check({tag, " data@send"}, o_tx_data, exp);
        check({tag, " op_err@send"}, o_op_err, 1'b0);
        @(negedge i_clk);
        check({tag, " start@wait"}, o_tx_start, 1'b0);
        check({tag, " data@wait"}, o_tx_data, exp);
        check({tag, " busy@wait"}, o_busy, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp, input logic exp_err);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check_result(tag, exp, exp_err);
    endtask

    task automatic finish_tx(input string tag);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check({tag, " busy@done"}, o_busy, 1'b0);
    endtask

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_vec      = 0;
        n_err      = 0;
        i_reset    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_done  = 1'b0;

        vecs.push_back('{"add",      8'h05, 8'h03, 8'h20, 8'h08, 1'b0});
        vecs.push_back('{"sub",      8'h03, 8'h05, 8'h22, 8'hFE, 1'b0});
        vecs.push_back('{"sra",      8'h80, 8'h02, 8'h03, 8'hE0, 1'b0});
        vecs.push_back('{"srl",      8'h80, 8'h02, 8'h02, 8'h20, 1'b0});
        vecs.push_back('{"bad_op",   8'h0F, 8'hF0, 8'h3F, 8'h00, 1'b1});
        vecs.push_back('{"and",      8'hCC, 8'hAA, 8'h24, 8'h88, 1'b0});
        vecs.push_back('{"or",       8'hCC, 8'hAA, 8'h25, 8'hEE, 1'b0});
        vecs.push_back('{"xor",      8'hCC, 8'hAA, 8'h26, 8'h66, 1'b0});
        vecs.push_back('{"nor",      8'hCC, 8'hAA, 8'h27, 8'h11, 1'b0});
        vecs.push_back('{"add_wrap", 8'hFF, 8'h02, 8'h20, 8'h01, 1'b0});
        vecs.push_back('{"sra_big",  8'h90, 8'h09, 8'h03, 8'hFF, 1'b0});
        vecs.push_back('{"sra_pos",  8'h70, 8'h0C, 8'h03, 8'h00, 1'b0});
        vecs.push_back('{"srl_big",  8'h90, 8'h08, 8'h02, 8'h00, 1'b0});
        vecs.push_back('{"op_hi",    8'h10, 8'h20, 8'hE0, 8'h30, 1'b0});

        // Reset state, observed while reset is held.
        idle(2);
        check("rst tx_data", o_tx_data, 8'h00);
        check("rst tx_start", o_tx_start, 1'b0);
        check("rst busy", o_busy, 1'b0);
        check("rst op_err", o_op_err, 1'b0);
        check("rst overrun", o_overrun, 1'b0);
        i_reset = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            run_frame(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].op,
                      vecs[i].exp, vecs[i].err);
            finish_tx(vecs[i].tag);
            idle(1);
        end

        // Extra byte while waiting for tx_done is dropped and flagged.
        run_frame("pre_ovr", 8'h06, 8'h03, 8'h22, 8'h03, 1'b0);
        send_byte(8'hAA);
        check("ovr pulse", o_overrun, 1'b1);
        check("ovr data", o_tx_data, 8'h03);
        check("ovr busy", o_busy, 1'b1);
        @(negedge i_clk);
        check("ovr clear", o_overrun, 1'b0);
        finish_tx("ovr");
        run_frame("post_ovr", 8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
        finish_tx("post_ovr");

        // tx_done outside WAIT_TX must not disturb a frame in progress.
        send_byte(8'h21);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check("stray_done busy", o_busy, 1'b0);
        check("stray_done start", o_tx_start, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        check_result("stray_done", 8'h10, 1'b0);
        finish_tx("stray_done");

        // Reset in the middle of a frame discards A and B.
        send_byte(8'h07);
        send_byte(8'h09);
        i_reset = 1'b0;
        #1;
        check("midrst tx_data", o_tx_data, 8'h00);
        check("midrst busy", o_busy, 1'b0);
        check("midrst start", o_tx_start, 1'b0);
        idle(2);
        check("midrst hold start", o_tx_start, 1'b0);
        i_reset = 1'b1;
        idle(1);
        run_frame("post_rst", 8'h02, 8'h02, 8'h24, 8'h02, 1'b0);
        finish_tx("post_rst");

`ifdef UART_ALU_INTF_TIMEOUT_EN
        // A lone byte followed by a long gap is abandoned; the next three
        // bytes form a fresh frame.
        send_byte(8'h11);
        idle(150);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        check_result("timeout", 8'h02, 1'b0);
        finish_tx("timeout");
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
